// File: rtl/phase_timer_bank.sv
// phase_timer_bank: prescaled TS1/TS2/TS3 phase timers pacing the traffic controller state machine.
// Loads the one-hot selected duration, counts it down in ticks and pulses triggerNextEvent on expiry.
module phase_timer_bank #(
    parameter int PRESCALE  = 50_000_000,
    parameter int CNT_W     = 8,
    parameter int TS1_TICKS = 30,
    parameter int TS2_TICKS = 5,
    parameter int TS3_TICKS = 20
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [2:0]       enableCounters,
    output logic             triggerNextEvent,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       activeTimer,
    output logic             illegalEnable
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    // Durations are truncated first, then a zero duration is promoted to one tick
    localparam logic [CNT_W-1:0] D1 = (CNT_W'(TS1_TICKS) == '0) ? CNT_W'(1) : CNT_W'(TS1_TICKS);
    localparam logic [CNT_W-1:0] D2 = (CNT_W'(TS2_TICKS) == '0) ? CNT_W'(1) : CNT_W'(TS2_TICKS);
    localparam logic [CNT_W-1:0] D3 = (CNT_W'(TS3_TICKS) == '0) ? CNT_W'(1) : CNT_W'(TS3_TICKS);

    typedef enum logic [1:0] {LOAD, RUN, FIRE} state_t;

    state_t           r_state, w_state;
    logic [PW-1:0]    r_pre, w_pre;
    logic [CNT_W-1:0] r_rem, w_rem;
    logic [1:0]       r_act, w_act;
    logic             r_trig, w_trig;
    logic             r_ill, w_ill;
    logic [2:0]       r_en, w_en;
    logic             w_tick;
    logic             w_onehot;
    logic [CNT_W-1:0] w_dur;
    logic [1:0]       w_code;

    assign w_tick   = (r_pre == PRE_MAX);
    assign w_onehot = $onehot(enableCounters);
    assign w_dur    = enableCounters[0] ? D1 : enableCounters[1] ? D2 : D3;
    assign w_code   = enableCounters[0] ? 2'd1 : enableCounters[1] ? 2'd2 : 2'd3;

    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_rem   = r_rem;
        w_act   = r_act;
        w_trig  = 1'b0;
        w_ill   = r_ill;
        w_en    = r_en;
        case (r_state)
            LOAD: begin
                if (w_onehot) begin
                    w_rem   = w_dur;
                    w_act   = w_code;
                    w_pre   = '0;
                    w_ill   = 1'b0;
                    w_en    = enableCounters;
                    w_state = RUN;
                end else begin
                    w_ill = 1'b1;
                    w_act = 2'd0;
                    w_rem = '0;
                end
            end
            RUN: begin
                // A changed select abandons the phase even in a tick cycle
                if (enableCounters != r_en) begin
                    w_state = LOAD;
                    w_pre   = '0;
                end else begin
                    w_pre = w_tick ? '0 : r_pre + 1'b1;
                    if (w_tick && r_rem > CNT_W'(1)) begin
                        w_rem = r_rem - 1'b1;
                    end else if (w_tick && r_rem == CNT_W'(1)) begin
                        w_rem   = '0;
                        w_trig  = 1'b1;
                        w_state = FIRE;
                    end
                end
            end
            FIRE:    w_state = LOAD;
            default: w_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= LOAD;
            r_pre   <= '0;
            r_rem   <= '0;
            r_act   <= 2'd0;
            r_trig  <= 1'b0;
            r_ill   <= 1'b0;
            r_en    <= 3'd0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_rem   <= w_rem;
            r_act   <= w_act;
            r_trig  <= w_trig;
            r_ill   <= w_ill;
            r_en    <= w_en;
        end
    end

    assign triggerNextEvent = r_trig;
    assign remaining        = r_rem;
    assign activeTimer      = r_act;
    assign illegalEnable    = r_ill;
endmodule

// File: tb/tb_phase_timer_bank.sv
// tb_phase_timer_bank: directed vectors for phase_timer_bank with PRESCALE=4, TS1/TS2/TS3 = 3/2/5.
// A second instance with TS2_TICKS=0 covers the zero-duration promotion.
module tb_phase_timer_bank;
    logic       clk;
    logic       resetN;
    logic [2:0] en;
    logic       trig;
    logic [7:0] rem;
    logic [1:0] act;
    logic       ill;
    logic [2:0] en_z;
    logic       trig_z;
    logic [7:0] rem_z;
    logic [1:0] act_z;
    logic       ill_z;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    phase_timer_bank #(.PRESCALE(4), .CNT_W(8), .TS1_TICKS(3), .TS2_TICKS(2), .TS3_TICKS(5)) u_dut (
        .clk(clk), .resetN(resetN), .enableCounters(en), .triggerNextEvent(trig),
        .remaining(rem), .activeTimer(act), .illegalEnable(ill)
    );

    phase_timer_bank #(.PRESCALE(4), .CNT_W(8), .TS1_TICKS(3), .TS2_TICKS(0), .TS3_TICKS(5)) u_zero (
        .clk(clk), .resetN(resetN), .enableCounters(en_z), .triggerNextEvent(trig_z),
        .remaining(rem_z), .activeTimer(act_z), .illegalEnable(ill_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Edges until the selected instance shows its trigger; 200 means it never came
    task automatic wait_trig(input bit sel, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(sel ? trig_z : trig) && n < 200);
    endtask

    logic [2:0] seq [7] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
    int         gap [7] = '{14, 10, 10, 22, 10, 22, 10};

    initial begin
        int n;
        int t_last;
        int t_start;
        int pulses;
        resetN = 1'b0;
        en     = 3'b001;
        en_z   = 3'b010;
        step(2);
        check("rst_trig", 32'(trig), 0);
        check("rst_rem", 32'(rem), 0);
        check("rst_act", 32'(act), 0);
        check("rst_ill", 32'(ill), 0);

        resetN = 1'b1;
        step(1);
        check("t1_rem3", 32'(rem), 3);
        check("t1_act", 32'(act), 1);
        check("t1_trig0", 32'(trig), 0);
        step(4);
        check("t1_rem2", 32'(rem), 2);
        step(4);
        check("t1_rem1", 32'(rem), 1);
        wait_trig(0, n);
        check("t1_fire_edge", n + 9, 13);
        check("t1_fire_rem", 32'(rem), 0);
        t_start = cyc;
        t_last  = cyc;
        step(1);
        check("t1_pulse_width", 32'(trig), 0);
        step(1);
        check("t1_reload", 32'(rem), 3);
        check("t1_reload_act", 32'(act), 1);

        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            wait_trig(0, n);
            check($sformatf("gap%0d", i), cyc - t_last, gap[i]);
            t_last = cyc;
            pulses += int'(trig);
            en = seq[(i + 1) % 7];
        end
        check("full_pulses", pulses, 7);
        check("full_period", cyc - t_start, 98);

        en = 3'b000;
        step(2);
        check("ill0_flag", 32'(ill), 1);
        check("ill0_act", 32'(act), 0);
        check("ill0_rem", 32'(rem), 0);
        en = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("ill3_trig", 32'(trig), 0);
            check("ill3_flag", 32'(ill), 1);
        end
        en = 3'b100;
        step(1);
        check("ts3_flag_clr", 32'(ill), 0);
        check("ts3_act", 32'(act), 3);
        check("ts3_rem", 32'(rem), 5);
        wait_trig(0, n);
        check("ts3_len", n, 20);

        en = 3'b010;
        step(2);
        check("mid_act2", 32'(act), 2);
        check("mid_rem2", 32'(rem), 2);
        step(3);
        en = 3'b001;
        step(1);
        check("mid_no_dec", 32'(rem), 2);
        check("mid_no_trig", 32'(trig), 0);
        step(1);
        check("mid_ts1_rem", 32'(rem), 3);
        check("mid_ts1_act", 32'(act), 1);
        wait_trig(0, n);
        check("mid_ts1_len", n, 12);

        resetN = 1'b0;
        #1;
        check("rfire_trig", 32'(trig), 0);
        check("rfire_rem", 32'(rem), 0);
        check("rfire_act", 32'(act), 0);
        check("rfire_ill", 32'(ill), 0);
        #2;
        resetN = 1'b1;
        wait_trig(0, n);
        check("rfire_restart", n, 13);

        wait_trig(1, n);
        step(2);
        check("zero_rem", 32'(rem_z), 1);
        check("zero_act", 32'(act_z), 2);
        wait_trig(1, n);
        check("zero_first", n, 4);
        wait_trig(1, n);
        check("zero_period", n, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
